// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states and
// a helper that sizes the iteration counter.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFin
  } mdu_state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide
// on a 2*WIDTH accumulator ({hi_part, lo_part}).
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) sum = sum + {1'b0, opnd};
    // Partial remainder shifted left with the next dividend bit brought in.
    trial = acc[2*WIDTH-1:WIDTH-1];
    diff  = trial - {1'b0, opnd};
    if (!is_div) begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Operands are reduced to magnitudes on start; signs are reapplied in the FIN cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_s,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = cnt_width(WIDTH);

  mdu_state_e           state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]     opnd_q;
  logic                 is_div_q, neg_q, neg_rem_q, divz_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 busy_q, done_q;

  logic                 is_signed, r_neg, s_neg;
  logic [WIDTH-1:0]     r_mag, s_mag;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  always_comb begin
    is_signed = ~i_op[0];
    r_neg     = is_signed & i_r[WIDTH-1];
    s_neg     = is_signed & i_s[WIDTH-1];
    r_mag     = r_neg ? -i_r : i_r;
    s_mag     = s_neg ? -i_s : i_s;
  end

  // Most-negative / -1 needs no special case: the negated magnitude wraps to itself.
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    if (divz_q) quo = '1;
    rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_start && !i_op[2]) begin
            is_div_q  <= i_op[1];
            neg_q     <= r_neg ^ s_neg;
            neg_rem_q <= i_op[1] & r_neg;
            divz_q    <= i_op[1] & (i_s == '0);
            acc_q     <= i_op[1] ? {{WIDTH{1'b0}}, r_mag} : {{WIDTH{1'b0}}, s_mag};
            opnd_q    <= i_op[1] ? s_mag : r_mag;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StCalc;
          end else if (i_start && i_op == MDU_MTHI) begin
            hi_q <= i_r;
          end else if (i_start && i_op == MDU_MTLO) begin
            lo_q <= i_r;
          end
        end
        StCalc: begin
          if (i_flush) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_q <= StFin;
          end
        end
        StFin: begin
          if (!i_flush) begin
            hi_q   <= is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
            lo_q   <= is_div_q ? quo : prod[WIDTH-1:0];
            done_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter at WIDTH=32 and WIDTH=8: expected HI/LO and completion
// cycle are queued at issue; monitors pop and compare on each o_done pulse.
module tb_mdu_iter;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start32 = 1'b0, flush32 = 1'b0;
  logic [2:0]  op32 = 3'b000;
  logic [31:0] r32 = '0, s32 = '0;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;
  logic        start8 = 1'b0;
  logic [2:0]  op8 = 3'b000;
  logic [7:0]  r8 = '0, s8 = '0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mdu_iter #(.WIDTH(32)) dut32 (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (start32), .i_op (op32), .i_r (r32),
    .i_s (s32), .i_flush (flush32), .o_busy (busy32), .o_done (done32), .o_hi (hi32),
    .o_lo (lo32)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (start8), .i_op (op8), .i_r (r8),
    .i_s (s8), .i_flush (1'b0), .o_busy (busy8), .o_done (done8), .o_hi (hi8),
    .o_lo (lo8)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done32) begin
      if (q32.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done32: got done hi=%h lo=%h, want no done", hi32, lo32);
      end else begin
        e32 = q32.pop_front();
        check("done32_hi", 64'(hi32), 64'(e32.hi));
        check("done32_lo", 64'(lo32), 64'(e32.lo));
        check("done32_cycle", 64'(cyc), 64'(e32.cyc));
        check("done32_busy_low", 64'(busy32), 64'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done8: got done hi=%h lo=%h, want no done", hi8, lo8);
      end else begin
        e8 = q8.pop_front();
        check("done8_hi", 64'(hi8), 64'(e8.hi));
        check("done8_lo", 64'(lo8), 64'(e8.lo));
        check("done8_cycle", 64'(cyc), 64'(e8.cyc));
      end
    end
  end

  // Called at a negedge; the start edge is cyc+1, completion WIDTH+1 edges later.
  task automatic issue32(input logic [2:0] op, input logic [31:0] r, input logic [31:0] s,
                         input logic [31:0] hi, input logic [31:0] lo);
    q32.push_back('{hi: hi, lo: lo, cyc: cyc + 34});
    start32 = 1'b1; op32 = op; r32 = r; s32 = s;
    @(negedge clk);
    start32 = 1'b0; flush32 = 1'b0;
    check("busy32_after_start", 64'(busy32), 64'(1));
  endtask

  task automatic wait32;
    int n = 0;
    while (!done32 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done32) check("timeout32", 64'(done32), 64'(1));
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] r, input logic [7:0] s,
                        input logic [7:0] hi, input logic [7:0] lo);
    int n = 0;
    q8.push_back('{hi: 32'(hi), lo: 32'(lo), cyc: cyc + 10});
    start8 = 1'b1; op8 = op; r8 = r; s8 = s;
    @(negedge clk);
    start8 = 1'b0;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done8) check("timeout8", 64'(done8), 64'(1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_hi", 64'(hi32), 64'(0));
    check("reset_lo", 64'(lo32), 64'(0));
    check("reset_busy_done", 64'({busy32, done32, busy8, done8}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    issue32(3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1); wait32();
    issue32(3'b011, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);       wait32();
    issue32(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD); wait32();
    issue32(3'b010, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF); wait32();
    issue32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000); wait32();

    // Second start during CALC must be dropped, not queued.
    issue32(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
    repeat (4) @(negedge clk);
    start32 = 1'b1; op32 = 3'b000; r32 = 32'd2; s32 = 32'd2;
    @(negedge clk);
    start32 = 1'b0;
    wait32();
    issue32(3'b011, 32'h0000_1000, 32'h10, 32'h0, 32'h0000_0100);         wait32();

    // Flush coinciding with a start in IDLE: the start wins.
    flush32 = 1'b1;
    issue32(3'b011, 32'd9, 32'd3, 32'h0, 32'h3);                          wait32();
    @(negedge clk);

    start32 = 1'b1; op32 = 3'b100; r32 = 32'hA5A5_A5A5;
    @(negedge clk);
    start32 = 1'b0;
    check("mthi_hi", 64'(hi32), 64'hA5A5_A5A5);
    check("mthi_lo_kept", 64'(lo32), 64'h3);
    check("mthi_busy", 64'(busy32), 64'(0));
    start32 = 1'b1; op32 = 3'b101; r32 = 32'h5A5A_5A5A;
    @(negedge clk);
    start32 = 1'b1; op32 = 3'b110; r32 = 32'h0;
    @(negedge clk);
    start32 = 1'b0;
    check("mtlo_then_nop", 64'({hi32, lo32}), 64'hA5A5_A5A5_5A5A_5A5A);
    check("nop_busy", 64'(busy32), 64'(0));

    // Flush at cycle 10 of a DIV: no done, HI/LO untouched.
    start32 = 1'b1; op32 = 3'b010; r32 = 32'd1000; s32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    flush32 = 1'b1;
    @(negedge clk);
    flush32 = 1'b0;
    check("flush_busy", 64'(busy32), 64'(0));
    check("flush_hilo", 64'({hi32, lo32}), 64'hA5A5_A5A5_5A5A_5A5A);
    repeat (40) @(negedge clk);
    check("flush_hilo_later", 64'({hi32, lo32}), 64'hA5A5_A5A5_5A5A_5A5A);

    issue8(3'b000, 8'h80, 8'hFF, 8'h00, 8'h80);
    issue8(3'b011, 8'd200, 8'd7, 8'h04, 8'h1C);

    // Asynchronous reset in the middle of CALC.
    start32 = 1'b1; op32 = 3'b001; r32 = 32'd77; s32 = 32'd11;
    @(negedge clk);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_hilo", 64'({hi32, lo32}), 64'(0));
    check("rst_mid_busy_done", 64'({busy32, done32}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_late_done", 64'({hi32, lo32}), 64'(0));

    check("q32_drained", 64'(q32.size()), 64'(0));
    check("q8_drained", 64'(q8.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
